// File: rtl/agg_unit.sv
// Windowed accumulate-and-activate stage: sums AGG_LEN samples and flags the window sum against AGG_THRESH.
// Optional macro AGG_SAT_EN makes accumulation saturate at all-ones instead of wrapping.
module agg_unit #(
  parameter int agg_width  = 12,
  parameter int AGG_LEN    = 4,
  parameter int AGG_THRESH = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [agg_width-1:0] agg_in,
  output logic [agg_width-1:0] agg_out2alu,
  output logic                 agg_out_acted
);

  localparam int CNT_W = (AGG_LEN > 1) ? $clog2(AGG_LEN) : 1;
  localparam logic [CNT_W-1:0]     LAST   = CNT_W'(AGG_LEN - 1);
  localparam logic [agg_width-1:0] THRESH = agg_width'(AGG_THRESH);

  logic [agg_width-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [agg_width-1:0] sum_out_q, sum_out_d;
  logic                 acted_q, acted_d;
  logic [agg_width:0]   sum;
  logic [agg_width-1:0] nsum;
  logic                 lastSample;

  assign sum        = {1'b0, acc_q} + {1'b0, agg_in};
  assign lastSample = (cnt_q == LAST);

`ifdef AGG_SAT_EN
  assign nsum = sum[agg_width] ? {agg_width{1'b1}} : sum[agg_width-1:0];
`else
  assign nsum = sum[agg_width-1:0];
`endif

  // Outputs only move on the last sample of a window; partial sums stay internal.
  always_comb begin
    acc_d     = nsum;
    cnt_d     = cnt_q + CNT_W'(1);
    sum_out_d = sum_out_q;
    acted_d   = acted_q;
    if (lastSample) begin
      acc_d     = '0;
      cnt_d     = '0;
      sum_out_d = nsum;
      acted_d   = (nsum >= THRESH);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      sum_out_q <= '0;
      acted_q   <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sum_out_q <= sum_out_d;
      acted_q   <= acted_d;
    end
  end

  assign agg_out2alu   = sum_out_q;
  assign agg_out_acted = acted_q;

endmodule

// File: tb/tb_agg_unit.sv
// Scoreboard bench for agg_unit: stimulus pushes the expected output for every edge, a monitor pops and compares.
// Build with or without AGG_SAT_EN; the overflow expectation follows the macro.
module tb_agg_unit;

  typedef struct {
    logic [11:0] sum;
    logic        acted;
  } expect_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] agg_in;
  logic [11:0] agg_out2alu;
  logic        agg_out_acted;

  expect_t     expQ[$];
  int          errCount   = 0;
  int          checkCount = 0;
  logic [11:0] heldSum    = '0;
  logic        heldActed  = 1'b0;

  agg_unit #(.agg_width(12), .AGG_LEN(4), .AGG_THRESH(1024)) dut (
    .clk(clk),
    .rst(rst),
    .agg_in(agg_in),
    .agg_out2alu(agg_out2alu),
    .agg_out_acted(agg_out_acted)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [11:0] expSum, input logic expActed);
    checkCount++;
    if (agg_out2alu !== expSum || agg_out_acted !== expActed) begin
      errCount++;
      $display("[TB] FAIL %s: got sum=%0d acted=%0b, expected sum=%0d acted=%0b",
               name, agg_out2alu, agg_out_acted, expSum, expActed);
    end
  endtask

  // Drive one sample half a cycle before the edge that captures it and queue what that edge must produce.
  task automatic applyStimulus(input logic [11:0] sample, input logic [11:0] expSum, input logic expActed);
    expect_t e;
    @(negedge clk);
    agg_in  = sample;
    e.sum   = expSum;
    e.acted = expActed;
    expQ.push_back(e);
  endtask

  task automatic applyWindow(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c,
                             input logic [11:0] d, input logic [11:0] expSum, input logic expActed);
    applyStimulus(a, heldSum, heldActed);
    applyStimulus(b, heldSum, heldActed);
    applyStimulus(c, heldSum, heldActed);
    applyStimulus(d, expSum, expActed);
    heldSum   = expSum;
    heldActed = expActed;
  endtask

  // Monitor: compares one queued expectation per rising edge, 1 time unit after the edge.
  initial begin
    expect_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("edge_check", e.sum, e.acted);
      end
    end
  end

  initial begin
    int waitCycles;
    rst    = 1'b0;
    agg_in = 12'd5;
    #1;
    checkOutput("reset_immediate", 12'd0, 1'b0);

    applyStimulus(12'd5, 12'd0, 1'b0);
    applyStimulus(12'd5, 12'd0, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;

    applyWindow(12'd1, 12'd3, 12'd2, 12'd1, 12'd7, 1'b0);
    applyWindow(12'd1024, 12'd0, 12'd0, 12'd0, 12'd1024, 1'b1);
    applyWindow(12'd1023, 12'd0, 12'd0, 12'd0, 12'd1023, 1'b0);
`ifdef AGG_SAT_EN
    applyWindow(12'd2048, 12'd2048, 12'd2, 12'd1, 12'd4095, 1'b1);
`else
    applyWindow(12'd2048, 12'd2048, 12'd2, 12'd1, 12'd3, 1'b0);
`endif
    applyWindow(12'd300, 12'd300, 12'd300, 12'd300, 12'd1200, 1'b1);
    applyWindow(12'd300, 12'd300, 12'd300, 12'd300, 12'd1200, 1'b1);

    // Partial window of 5+5 is thrown away by an asynchronous reset pulse between edges.
    applyStimulus(12'd5, heldSum, heldActed);
    applyStimulus(12'd5, heldSum, heldActed);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("reset_midwindow", 12'd0, 1'b0);
    heldSum   = '0;
    heldActed = 1'b0;
    applyStimulus(12'd7, 12'd0, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    applyWindow(12'd1, 12'd1, 12'd1, 12'd1, 12'd4, 1'b0);

    waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    if (expQ.size() > 0) begin
      checkCount++;
      errCount++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/agg_unit.md
# agg_unit

Windowed accumulate-and-activate stage of the neuron datapath. It sums a fixed-length window of unsigned `agg_width`-bit samples arriving one per clock. At the end of each window it presents the sum to the downstream ALU, together with a one-bit activation flag computed by threshold compare. It is free-running, with no handshake: every clock edge consumes one sample.

## Interface
Parameters:
- `agg_width`, default 12: width of the input sample, the accumulator and the ALU output.
- `AGG_LEN`, default 4: samples per window. Legal range is 2..256.
- `AGG_THRESH`, default 1024: activation threshold, unsigned, must be less than 2^agg_width.

Ports (one clock; reset is asynchronous and active-low):
- `clk`, input, 1 bit: single clock. All state updates on the rising edge.
- `rst`, input, 1 bit: asynchronous, active-low reset. Asserted when 0.
- `agg_in`, input, `agg_width` bits: unsigned sample, captured on every rising edge.
- `agg_out2alu`, output, `agg_width` bits: registered window sum.
- `agg_out_acted`, output, 1 bit: registered activation flag for the same window.

## Operation
- State:
  - `acc`: partial sum, `agg_width` bits.
  - `cnt`: sample index, 0..AGG_LEN-1, width clog2(AGG_LEN).
  - The two output registers.
- Every rising edge with `rst` deasserted, compute `sum = acc + agg_in` in `agg_width+1` bits. Then `nsum` is:
  - with saturation compiled in, the all-ones value 2^agg_width-1 if bit `agg_width` of `sum` is set, otherwise `sum` truncated;
  - without it, `sum` truncated to `agg_width` bits (modulo wrap).
- If `cnt < AGG_LEN-1`:
  - `acc <= nsum`, `cnt <= cnt+1`.
  - Outputs hold their values.
- If `cnt == AGG_LEN-1` (last sample of the window):
  - `agg_out2alu <= nsum`.
  - `agg_out_acted <= (nsum >= AGG_THRESH)`, unsigned compare.
  - `acc <= 0`, `cnt <= 0`. The next window starts on the following edge; there is no gap cycle.
- Activation is a pure threshold step on the final, saturated-or-wrapped sum. Intermediate partial sums never drive the outputs.

## Timing
- Reset (`rst` = 0), asynchronous, takes effect immediately without waiting for a clock edge:
  - `acc`, `cnt`, `agg_out2alu` and `agg_out_acted` clear to 0.
  - While reset is held, the inputs are ignored.
- The first edge after reset deassertion captures sample 0 of window 0.
- Latency: the outputs change on the same edge that captures sample AGG_LEN-1. The window sum is visible immediately after that edge.
- Update rate: outputs change at most once every AGG_LEN cycles and are stable in between.
- Reset mid-window discards the partial sum. The window count restarts at 0.
- Saturation is evaluated on every addition, so once the partial sum has saturated it stays at all-ones for the rest of the window.
- No combinational path from `agg_in` to any output.

## Configuration
- Macro `AGG_SAT_EN`:
  - Defined: accumulator additions saturate at 2^agg_width-1.
  - Undefined: additions wrap modulo 2^agg_width, and the activation compare uses the wrapped value.

## Test plan
All scenarios use defaults `agg_width`=12, `AGG_LEN`=4, `AGG_THRESH`=1024.
- Reset: hold `rst`=0 for 2 cycles with `agg_in`=5. Both outputs read 0 throughout and immediately on assertion, including assertion between clock edges.
- Basic window: after reset, `agg_in` = 1, 3, 2, 1 on consecutive edges. After the 4th edge `agg_out2alu`=7 and `agg_out_acted`=0. Both hold for the next 3 edges.
- Threshold boundary:
  - window 1024, 0, 0, 0 gives 1024 and `agg_out_acted`=1;
  - window 1023, 0, 0, 0 gives 1023 and `agg_out_acted`=0.
- Overflow: window 2048, 2048, 2, 1.
  - With `AGG_SAT_EN`: 4095, acted=1.
  - Without: 3, acted=0.
- Mid-window reset: feed 5, 5, then pulse `rst` low asynchronously. Then feed 1, 1, 1, 1. The result is 4, and it appears 4 edges after the release.
- Back-to-back windows: 8 consecutive samples, all 300. Outputs read 1200/1 after edge 4 and again after edge 8, with no change in between.
